// File: rtl/julia_iter_sched_if.sv
// Handshake and multiplier bus for julia_iter_sched.
// slave: scheduler side. master: job source / result sink / multiplier side.
interface julia_iter_sched_if #(
    parameter int unsigned ITER_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       c_re;
    logic [31:0]       c_im;
    logic [31:0]       z0_re;
    logic [31:0]       z0_im;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_val;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;

    modport slave (
        input  in_valid, c_re, c_im, z0_re, z0_im, mul_val, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_iter, out_escaped
    );

    modport master (
        output in_valid, c_re, c_im, z0_re, z0_im, mul_val, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_iter, out_escaped
    );
endinterface

// File: rtl/julia_iter_sched.sv
// Julia-set per-pixel iteration scheduler, z <= z^2 + c in Q16.16.
// Shares one external combinational multiplier across zr*zr, zi*zi, zr*zi,
// four cycles per iteration. Define JULIA_STATS_EN to add job/escape counters.
module julia_iter_sched #(
    parameter int unsigned MAX_ITER  = 64,
    parameter int unsigned ITER_W    = 8,
    parameter logic [31:0] ESC_LIMIT = 32'h0004_0000
) (
    input  logic              clk,
    input  logic              rst,
    julia_iter_sched_if.slave bus
`ifdef JULIA_STATS_EN
    ,
    output logic [31:0]       stat_jobs,
    output logic [31:0]       stat_escaped
`endif
);

    localparam logic [ITER_W-1:0] MaxIterW = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {StIdle, StSqRe, StSqIm, StCross, StUpdate, StDone} state_e;

    state_e state_q, state_d;

    logic [31:0]       zr_q, zr_d, zi_q, zi_d;
    logic [31:0]       cr_q, cr_d, ci_q, ci_d;
    logic [31:0]       rr_q, rr_d, ii_q, ii_d, ri_q, ri_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              out_valid_q, out_valid_d;
    logic [ITER_W-1:0] out_iter_q, out_iter_d;
    logic              out_escaped_q, out_escaped_d;

    // |z|^2 as a 33-bit signed sum so two large positive squares cannot wrap negative
    logic signed [32:0] mag;
    logic               escape;
    assign mag    = $signed({rr_q[31], rr_q}) + $signed({ii_q[31], ii_q});
    assign escape = mag > $signed({1'b0, ESC_LIMIT});

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic: fixed four-cycle iteration loop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.in_valid) state_d = StSqRe;
            StSqRe:   state_d = StSqIm;
            StSqIm:   state_d = StCross;
            StCross:  state_d = StUpdate;
            StUpdate: state_d = (escape || iter_q == MaxIterW) ? StDone : StSqRe;
            StDone:   if (bus.out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: ready flag and multiplier operand steering
    always_comb begin
        bus.in_ready = (state_q == StIdle);
        bus.mul_a    = '0;
        bus.mul_b    = '0;
        unique case (state_q)
            StSqRe: begin
                bus.mul_a = zr_q;
                bus.mul_b = zr_q;
            end
            StSqIm: begin
                bus.mul_a = zi_q;
                bus.mul_b = zi_q;
            end
            StCross: begin
                bus.mul_a = zr_q;
                bus.mul_b = zi_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state: capture products, iterate z, publish result
    always_comb begin
        zr_d          = zr_q;
        zi_d          = zi_q;
        cr_d          = cr_q;
        ci_d          = ci_q;
        rr_d          = rr_q;
        ii_d          = ii_q;
        ri_d          = ri_q;
        iter_d        = iter_q;
        out_valid_d   = out_valid_q;
        out_iter_d    = out_iter_q;
        out_escaped_d = out_escaped_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    cr_d   = bus.c_re;
                    ci_d   = bus.c_im;
                    zr_d   = bus.z0_re;
                    zi_d   = bus.z0_im;
                    iter_d = '0;
                end
            end
            StSqRe:  rr_d = bus.mul_val;
            StSqIm:  ii_d = bus.mul_val;
            StCross: ri_d = bus.mul_val;
            StUpdate: begin
                if (escape) begin
                    out_valid_d   = 1'b1;
                    out_iter_d    = iter_q;
                    out_escaped_d = 1'b1;
                end else if (iter_q == MaxIterW) begin
                    out_valid_d   = 1'b1;
                    out_iter_d    = MaxIterW;
                    out_escaped_d = 1'b0;
                end else begin
                    zr_d   = rr_q - ii_q + cr_q;
                    zi_d   = {ri_q[30:0], 1'b0} + ci_q;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            StDone: if (bus.out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            zr_q          <= '0;
            zi_q          <= '0;
            cr_q          <= '0;
            ci_q          <= '0;
            rr_q          <= '0;
            ii_q          <= '0;
            ri_q          <= '0;
            iter_q        <= '0;
            out_valid_q   <= 1'b0;
            out_iter_q    <= '0;
            out_escaped_q <= 1'b0;
        end else begin
            zr_q          <= zr_d;
            zi_q          <= zi_d;
            cr_q          <= cr_d;
            ci_q          <= ci_d;
            rr_q          <= rr_d;
            ii_q          <= ii_d;
            ri_q          <= ri_d;
            iter_q        <= iter_d;
            out_valid_q   <= out_valid_d;
            out_iter_q    <= out_iter_d;
            out_escaped_q <= out_escaped_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_iter    = out_iter_q;
    assign bus.out_escaped = out_escaped_q;

`ifdef JULIA_STATS_EN
    logic [31:0] stat_jobs_q, stat_jobs_d, stat_escaped_q, stat_escaped_d;

    // Count completed output handshakes
    always_comb begin
        stat_jobs_d    = stat_jobs_q;
        stat_escaped_d = stat_escaped_q;
        if (out_valid_q && bus.out_ready) begin
            stat_jobs_d = stat_jobs_q + 32'd1;
            if (out_escaped_q) stat_escaped_d = stat_escaped_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_jobs_q    <= '0;
            stat_escaped_q <= '0;
        end else begin
            stat_jobs_q    <= stat_jobs_d;
            stat_escaped_q <= stat_escaped_d;
        end
    end

    assign stat_jobs    = stat_jobs_q;
    assign stat_escaped = stat_escaped_q;
`endif

endmodule

// File: tb/tb_julia_iter_sched.sv
// Randomized self-checking bench for julia_iter_sched with a plain-arithmetic
// reference model of the Julia iteration. Supports JULIA_STATS_EN builds.
module tb_julia_iter_sched;

    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    julia_iter_sched_if #(.ITER_W(ITER_W)) bus ();

`ifdef JULIA_STATS_EN
    logic [31:0] stat_jobs;
    logic [31:0] stat_escaped;
    int          exp_jobs;
    int          exp_esc_cnt;
`endif

    julia_iter_sched #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef JULIA_STATS_EN
        ,
        .stat_jobs    (stat_jobs),
        .stat_escaped (stat_escaped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = a * b;
        return p[47:16];
    endfunction

    // Shared combinational multiplier
    assign bus.mul_val = qmul(bus.mul_a, bus.mul_b);

    // Reference: iterate z^2 + c until |z|^2 > 4.0 or the iteration cap
    function automatic void model(input logic [31:0] cr, input logic [31:0] ci,
                                  input logic [31:0] z0r, input logic [31:0] z0i,
                                  output int it, output bit esc);
        logic [31:0] zr, zi, rr, ii, ri;
        logic signed [32:0] mag;
        zr  = z0r;
        zi  = z0i;
        it  = MAX_ITER;
        esc = 1'b0;
        for (int n = 0; n <= MAX_ITER; n++) begin
            rr  = qmul(zr, zr);
            ii  = qmul(zi, zi);
            ri  = qmul(zr, zi);
            mag = $signed({rr[31], rr}) + $signed({ii[31], ii});
            if (mag > 33'sd262144) begin
                it  = n;
                esc = 1'b1;
                return;
            end
            if (n == MAX_ITER) return;
            zr = rr - ii + cr;
            zi = (ri << 1) + ci;
        end
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // want_it < 0 means take the expectation from the model
    task automatic run_job(input logic [31:0] cr, input logic [31:0] ci,
                           input logic [31:0] z0r, input logic [31:0] z0i,
                           input int hold, input int want_it, input bit want_esc);
        int exp_it;
        bit exp_esc;
        int cycles;
        int waitc;
        logic [ITER_W-1:0] it_seen;
        logic esc_seen;
        if (want_it < 0) model(cr, ci, z0r, z0i, exp_it, exp_esc);
        else begin
            exp_it  = want_it;
            exp_esc = want_esc;
        end
        bus.c_re     = cr;
        bus.c_im     = ci;
        bus.z0_re    = z0r;
        bus.z0_im    = z0i;
        bus.in_valid = 1'b1;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check_eq("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble upstream after accept: the job must already be latched
        bus.in_valid = 1'b0;
        bus.c_re     = $urandom;
        bus.c_im     = $urandom;
        bus.z0_re    = $urandom;
        bus.z0_im    = $urandom;
        cycles = 0;
        while (!bus.out_valid && cycles < 4 * (MAX_ITER + 1) + 8) begin
            if (cycles == 0) begin
                check_eq("sq_re_mul_a", 64'(bus.mul_a), 64'(z0r));
                check_eq("sq_re_mul_b", 64'(bus.mul_b), 64'(z0r));
                check_eq("busy_in_ready", 64'(bus.in_ready), 64'd0);
            end else if (cycles == 1) begin
                check_eq("sq_im_mul_a", 64'(bus.mul_a), 64'(z0i));
                check_eq("sq_im_mul_b", 64'(bus.mul_b), 64'(z0i));
            end else if (cycles == 2) begin
                check_eq("cross_mul_a", 64'(bus.mul_a), 64'(z0r));
                check_eq("cross_mul_b", 64'(bus.mul_b), 64'(z0i));
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("latency", 64'(cycles), 64'(4 * (exp_it + 1)));
        check_eq("out_iter", 64'(bus.out_iter), 64'(exp_it));
        check_eq("out_escaped", 64'(bus.out_escaped), 64'(exp_esc));
        it_seen  = bus.out_iter;
        esc_seen = bus.out_escaped;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            check_eq("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check_eq("hold_out_iter", 64'(bus.out_iter), 64'(it_seen));
            check_eq("hold_out_escaped", 64'(bus.out_escaped), 64'(esc_seen));
            check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("post_hs_out_iter_kept", 64'(bus.out_iter), 64'(exp_it));
`ifdef JULIA_STATS_EN
        exp_jobs++;
        if (exp_esc) exp_esc_cnt++;
        check_eq("stat_jobs", 64'(stat_jobs), 64'(exp_jobs));
        check_eq("stat_escaped", 64'(stat_escaped), 64'(exp_esc_cnt));
`endif
    endtask

    function automatic logic [31:0] rnd_q(input int unsigned span);
        return 32'($urandom_range(0, 2 * span)) - 32'(span);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        n_checks = 0;
        n_fail   = 0;
`ifdef JULIA_STATS_EN
        exp_jobs    = 0;
        exp_esc_cnt = 0;
`endif
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.c_re      = '0;
        bus.c_im      = '0;
        bus.z0_re     = '0;
        bus.z0_im     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_iter", 64'(bus.out_iter), 64'd0);
        check_eq("rst_out_escaped", 64'(bus.out_escaped), 64'd0);
        check_eq("rst_mul_a", 64'(bus.mul_a), 64'd0);
        check_eq("rst_mul_b", 64'(bus.mul_b), 64'd0);

        // Directed cases with hand-derived results
        run_job(32'h0, 32'h0, 32'h0, 32'h0, 0, MAX_ITER, 1'b0);
        run_job(32'h0, 32'h0, 32'h0003_0000, 32'h0, 0, 0, 1'b1);
        run_job(32'h0, 32'h0, 32'h0002_0000, 32'h0, 0, 1, 1'b1);
        run_job(32'h0, 32'h0, 32'h0001_8000, 32'h0, 10, 1, 1'b1);
        run_job(32'h0, 32'h0, 32'h0, 32'hFFFD_0000, 3, 0, 1'b1);

        // Reset while the job sits in SQ_IM
        bus.c_re     = 32'h0;
        bus.c_im     = 32'h0;
        bus.z0_re    = 32'h0;
        bus.z0_im    = 32'h0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_mul_a", 64'(bus.mul_a), 64'd0);
`ifdef JULIA_STATS_EN
        exp_jobs    = 0;
        exp_esc_cnt = 0;
        check_eq("midrst_stat_jobs", 64'(stat_jobs), 64'd0);
        check_eq("midrst_stat_escaped", 64'(stat_escaped), 64'd0);
`endif
        seen = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 * (MAX_ITER + 2); k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        bus.out_ready = 1'b0;
        check_eq("midrst_no_result", 64'(seen), 64'd0);

        // Randomized jobs around the interesting |z| < 2 region
        for (int j = 0; j < 30; j++) begin
            run_job(rnd_q(32'h0001_8000), rnd_q(32'h0001_8000),
                    rnd_q(32'h0002_0000), rnd_q(32'h0002_0000),
                    int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
